// File: rtl/frame_sequencer_pkg.sv
// Shared game-display constants: VGA 640x480 timing, updater indices and the
// coordinate width, plus the update sequencer state type.
package frame_sequencer_pkg;

  localparam int COORD_W = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int N_UPD      = 3;
  localparam int UPD_PADDLE = 0;
  localparam int UPD_BALL   = 1;
  localparam int UPD_BLOCK  = 2;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_REQ,
    SEQ_GAP
  } seq_state_t;

endpackage

// File: rtl/frame_sequencer_vga_raster_counter.sv
// Pixel-enable divider and raster counters with registered sync/visible decode
// and strobes marking the start of vertical blank and of a new frame.
module vga_raster_counter #(
  parameter int H_VISIBLE = frame_sequencer_pkg::H_VISIBLE,
  parameter int H_FRONT   = frame_sequencer_pkg::H_FRONT,
  parameter int H_SYNC    = frame_sequencer_pkg::H_SYNC,
  parameter int H_BACK    = frame_sequencer_pkg::H_BACK,
  parameter int V_VISIBLE = frame_sequencer_pkg::V_VISIBLE,
  parameter int V_FRONT   = frame_sequencer_pkg::V_FRONT,
  parameter int V_SYNC    = frame_sequencer_pkg::V_SYNC,
  parameter int V_BACK    = frame_sequencer_pkg::V_BACK
) (
  input  logic                                 clock,
  input  logic                                 reset,
  output logic                                 pix_en,
  output logic                                 hsync,
  output logic                                 vsync,
  output logic                                 visible,
  output logic [frame_sequencer_pkg::COORD_W-1:0] pix_x,
  output logic [frame_sequencer_pkg::COORD_W-1:0] pix_y,
  output logic                                 vblank_start,
  output logic                                 frame_start
);
  import frame_sequencer_pkg::*;

  localparam int HT       = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT       = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic               line_end;
  logic               last_line;
  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;

  always_comb begin
    line_end  = (pix_x == COORD_W'(HT - 1));
    last_line = (pix_y == COORD_W'(VT - 1));
    next_x    = line_end ? '0 : pix_x + COORD_W'(1);
    next_y    = pix_y;
    if (line_end) next_y = last_line ? '0 : pix_y + COORD_W'(1);
  end

  assign vblank_start = pix_en && line_end && (pix_y == COORD_W'(V_VISIBLE - 1));
  assign frame_start  = pix_en && line_end && last_line;

  // Decode from the next position so sync/visible land on the same edge as the counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_en  <= 1'b0;
      pix_x   <= '0;
      pix_y   <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      visible <= 1'b0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        pix_x   <= next_x;
        pix_y   <= next_y;
        hsync   <= !((next_x >= COORD_W'(HS_START)) && (next_x <= COORD_W'(HS_END)));
        vsync   <= !((next_y >= COORD_W'(VS_START)) && (next_y <= COORD_W'(VS_END)));
        visible <= (next_x < COORD_W'(H_VISIBLE)) && (next_y < COORD_W'(V_VISIBLE));
      end
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Display timing master: raster generation, frame counting and a vblank-time
// scheduler that runs the game-state updaters one at a time.
module frame_sequencer #(
  parameter int H_VISIBLE = frame_sequencer_pkg::H_VISIBLE,
  parameter int H_FRONT   = frame_sequencer_pkg::H_FRONT,
  parameter int H_SYNC    = frame_sequencer_pkg::H_SYNC,
  parameter int H_BACK    = frame_sequencer_pkg::H_BACK,
  parameter int V_VISIBLE = frame_sequencer_pkg::V_VISIBLE,
  parameter int V_FRONT   = frame_sequencer_pkg::V_FRONT,
  parameter int V_SYNC    = frame_sequencer_pkg::V_SYNC,
  parameter int V_BACK    = frame_sequencer_pkg::V_BACK,
  parameter int N_UPD     = frame_sequencer_pkg::N_UPD
) (
  input  logic                                    clock,
  input  logic                                    reset,
  output logic                                    pix_en,
  output logic                                    hsync,
  output logic                                    vsync,
  output logic                                    visible,
  output logic [frame_sequencer_pkg::COORD_W-1:0] pix_x,
  output logic [frame_sequencer_pkg::COORD_W-1:0] pix_y,
  output logic [N_UPD-1:0]                        upd_req,
  input  logic [N_UPD-1:0]                        upd_done,
  output logic [15:0]                             frame_cnt,
  output logic                                    overrun
);
  import frame_sequencer_pkg::*;

  localparam int IDX_W = (N_UPD > 1) ? $clog2(N_UPD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_UPD - 1);

  logic             vblank_start;
  logic             frame_start;
  seq_state_t       state;
  seq_state_t       state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             done_now;
  logic             abort;

  vga_raster_counter #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_raster (
    .clock        (clock),
    .reset        (reset),
    .pix_en       (pix_en),
    .hsync        (hsync),
    .vsync        (vsync),
    .visible      (visible),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .vblank_start (vblank_start),
    .frame_start  (frame_start)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= SEQ_IDLE;
      idx       <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      overrun <= abort;
      if (vblank_start) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Only the currently requested client's done bit is ever looked at.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    abort      = 1'b0;
    upd_req    = '0;
    done_now   = 1'b0;
    for (int i = 0; i < N_UPD; i++) begin
      if (idx == IDX_W'(i)) done_now = upd_done[i];
    end
    case (state)
      SEQ_IDLE: begin
        if (vblank_start) begin
          state_next = SEQ_REQ;
          idx_next   = IDX_W'(UPD_PADDLE);
        end
      end
      SEQ_REQ: begin
        for (int i = 0; i < N_UPD; i++) begin
          if (idx == IDX_W'(i)) upd_req[i] = 1'b1;
        end
        if (done_now) state_next = SEQ_GAP;
      end
      SEQ_GAP: begin
        if (idx == LAST_IDX) begin
          state_next = SEQ_IDLE;
        end else begin
          idx_next   = idx + IDX_W'(1);
          state_next = SEQ_REQ;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
    // A last client finishing on the frame-start clock still counts as complete.
    if (frame_start && (state != SEQ_IDLE) &&
        !((state == SEQ_REQ) && (idx == LAST_IDX) && done_now)) begin
      abort      = 1'b1;
      state_next = SEQ_IDLE;
    end
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Master timing and update scheduler for the game display path. It divides the system clock into a pixel-enable phase and generates VGA 640x480 raster timing: sync pulses, the visible flag and pixel coordinates that feed the pixel compositor and the sprite/block renderers. At the start of each vertical blank it sequences the game-state updaters (paddle, ball, blocks) one at a time over a req/done handshake. This guarantees object state never changes while the frame is being drawn.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
N_UPD, 3, number of updater clients; index 0 = paddle, 1 = ball, 2 = blocks

Ports:
clock  input  1  system clock (2x pixel rate)
reset  input  1  synchronous, active-high
pix_en  output  1  high on every second clock; raster advances only on these cycles
hsync  output  1  horizontal sync, active-low
vsync  output  1  vertical sync, active-low
visible  output  1  high while pix_x < H_VISIBLE and pix_y < V_VISIBLE
pix_x  output  10  current horizontal count, 0..H_total-1 (H_total = 800)
pix_y  output  10  current vertical count, 0..V_total-1 (V_total = 525)
upd_req  output  N_UPD  one-hot update request to updater i
upd_done  input  N_UPD  updater i completion; sampled only for the currently requested index
frame_cnt  output  16  frames started; wraps modulo 2^16
overrun  output  1  one-clock pulse when update sequence is aborted by frame start

Behaviour:
- Reset values: pix_en=0, hsync=1, vsync=1, visible=0, pix_x=0, pix_y=0, upd_req=0, frame_cnt=0, overrun=0. Sequencer state is IDLE.
- pix_en toggles every clock: 0 on the first cycle after reset, then 1, 0, and so on.
- On a clock where pix_en=1, pix_x increments. At H_total-1 it wraps to 0 and pix_y increments. pix_y wraps to 0 after V_total-1.
- hsync=0 when pix_x is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751. vsync=0 when pix_y is in 490..491. Both are registered and aligned with pix_x/pix_y, so all raster outputs change on the same clock. visible follows the same alignment.
- vblank_start event: the pix_en cycle on which the raster moves to (pix_x=0, pix_y=V_VISIBLE). frame_start event: the pix_en cycle on which the raster moves to (0,0).
- On vblank_start, frame_cnt increments, wrapping 0xFFFF to 0x0000.
- Sequencer FSM states: IDLE, REQ(i), GAP.
  - IDLE: on vblank_start, set i=0, enter REQ.
  - REQ: upd_req[i]=1, held until upd_done[i]=1 is sampled. Latency is unbounded until frame_start. On the clock done is sampled, upd_req drops to 0 next cycle and the FSM enters GAP.
  - GAP: one clock with upd_req=0. Then, if i=N_UPD-1, go to IDLE; otherwise i=i+1 and go to REQ.
- Client isolation: upd_done bits other than index i are ignored. A done held high across GAP does not complete the next client early, because only the new index is sampled.
- Abort rule: if frame_start occurs while in REQ or GAP, upd_req clears to 0, the FSM returns to IDLE and overrun pulses for 1 clock. If upd_done[N_UPD-1] is sampled on that same clock, the sequence counts as complete and there is no overrun.
- vblank_start while not in IDLE cannot occur (a frame start always intervenes). No special handling is needed.
- Reset mid-sequence: all outputs return to reset values on the next clock; no overrun pulse.

Decomposition:
- Shared game package holds: VGA timing constants (H/V visible, porch and sync widths, H_total, V_total); the updater index constants UPD_PADDLE=0, UPD_BALL=1, UPD_BLOCK=2; and the coordinate width (10).
- One sub-module, vga_raster_counter, owns pix_en, the counters, the sync/visible decode and the vblank_start/frame_start strobes.
- frame_sequencer instantiates it and adds frame_cnt and the update FSM.

Test Plan:
- Reset then free-run: pix_en alternates 0,1. pix_x reaches 799 and wraps. One frame = 840000 clocks. hsync is low for exactly 192 clocks per line. vsync is low for 2 lines (3200 clocks).
- Visible window: visible=1 exactly for pix_x 0..639 with pix_y 0..479. visible=0 at (640,0) and at (0,480).
- Cooperative updaters respond 3 clocks after req: req[0], then req[1], then req[2] in order, each followed by a 1-clock gap. FSM returns to IDLE. No overrun. frame_cnt=1 after the first vblank_start.
- Updater 1 never asserts done: req[1] stays high until frame_start. Then upd_req=0, overrun pulses for 1 clock, and the next vblank restarts at req[0].
- Spurious done: hold upd_done=3'b111 constantly. Each request completes after 1 clock, with a gap between requests. No client is skipped.
- Reset asserted while req[1] is high: all outputs take reset values on the next clock. No overrun. frame_cnt=0.
